// File: rtl/i2c_pad_filter.sv
// I2C pad input filter: 2-flop synchronizers, per-line stability filter, glitch counter.
// Define I2C_PAD_FILTER_COND_DETECT_EN to build START/STOP detection and the bus-busy FSM.
module i2c_pad_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic       io_clock,
  input  logic       io_reset_n,
  input  logic       io_scl_pad,
  input  logic       io_sda_pad,
  input  logic       io_stats_clear,
  output logic       io_scl_read,
  output logic       io_sda_read,
  output logic       io_start,
  output logic       io_stop,
  output logic       io_busy,
  output logic [7:0] io_glitch_count
);

  localparam logic [3:0] LP_FC = 4'(FILTER_CYCLES);

  // Bit 0 carries SCL, bit 1 carries SDA throughout.
  logic [1:0]      w_pad;
  logic [1:0]      r_sync_p0;
  logic [1:0]      r_sync_p1;
  logic [1:0]      r_filt_p2;
  logic [1:0][3:0] r_cnt;
  logic [1:0]      w_glitch;
  logic [1:0]      w_glitch_inc;
  logic [7:0]      r_glitch_count;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign w_pad = {io_sda_pad, io_scl_pad};

  always_comb begin
    w_glitch = '0;
    for (int i = 0; i < 2; i++) begin
      w_glitch[i] = (r_sync_p1[i] == r_filt_p2[i]) && (r_cnt[i] != 4'd0);
    end
    w_glitch_inc = {1'b0, w_glitch[0]} + {1'b0, w_glitch[1]};
  end

  // p0/p1: synchronizer; p2: filtered level, updated after FILTER_CYCLES stable cycles
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_sync_p0 <= 2'b11;
      r_sync_p1 <= 2'b11;
      r_filt_p2 <= 2'b11;
      r_cnt     <= '0;
    end else begin
      r_sync_p0 <= w_pad;
      r_sync_p1 <= r_sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync_p1[i] != r_filt_p2[i]) begin
          if (r_cnt[i] + 4'd1 == LP_FC) begin
            r_filt_p2[i] <= r_sync_p1[i];
            r_cnt[i]     <= 4'd0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 4'd1;
          end
        end else begin
          r_cnt[i] <= 4'd0;
        end
      end
    end
  end

  // Clear takes priority over any increment landing in the same cycle.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_glitch_count <= 8'd0;
    end else if (io_stats_clear) begin
      r_glitch_count <= 8'd0;
    end else begin
      r_glitch_count <= sat_add(r_glitch_count, w_glitch_inc);
    end
  end

  assign io_scl_read     = r_filt_p2[0];
  assign io_sda_read     = r_filt_p2[1];
  assign io_glitch_count = r_glitch_count;

`ifdef I2C_PAD_FILTER_COND_DETECT_EN
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t     r_state;
  logic [1:0] r_filt_q;
  logic       r_start;
  logic       r_stop;
  logic       w_scl_hi;
  logic       w_start_cond;
  logic       w_stop_cond;

  // Simultaneous SCL/SDA edges never qualify since SCL must be high in both cycles.
  assign w_scl_hi     = r_filt_p2[0] & r_filt_q[0];
  assign w_start_cond = w_scl_hi & r_filt_q[1] & ~r_filt_p2[1];
  assign w_stop_cond  = w_scl_hi & ~r_filt_q[1] & r_filt_p2[1];

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_state  <= ST_IDLE;
      r_filt_q <= 2'b11;
      r_start  <= 1'b0;
      r_stop   <= 1'b0;
    end else begin
      r_filt_q <= r_filt_p2;
      r_start  <= w_start_cond;
      r_stop   <= w_stop_cond;
      case (r_state)
        ST_IDLE: if (w_start_cond) r_state <= ST_BUSY;
        ST_BUSY: if (w_stop_cond)  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_start = r_start;
  assign io_stop  = r_stop;
  assign io_busy  = (r_state == ST_BUSY);
`else
  assign io_start = 1'b0;
  assign io_stop  = 1'b0;
  assign io_busy  = 1'b0;
`endif

endmodule

// File: doc/i2c_pad_filter.md
I2C_PAD_FILTER -- requirements
Module: i2c_pad_filter

Interface
REQ-001 SHALL provide parameter FILTER_CYCLES, default 3: consecutive stable synchronized cycles needed to accept a new line level; legal range 1..15.
REQ-002 SHALL provide port io_clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL provide port io_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port io_scl_pad  input  1  raw SCL from pad input buffer, asynchronous to io_clock.
REQ-005 SHALL provide port io_sda_pad  input  1  raw SDA from pad input buffer, asynchronous to io_clock.
REQ-006 SHALL provide port io_stats_clear  input  1  synchronous clear of io_glitch_count.
REQ-007 SHALL provide port io_scl_read  output  1  filtered SCL to the I2C controller read input.
REQ-008 SHALL provide port io_sda_read  output  1  filtered SDA to the I2C controller read input.
REQ-009 SHALL provide port io_start  output  1  one-cycle pulse on START or repeated START.
REQ-010 SHALL provide port io_stop  output  1  one-cycle pulse on STOP.
REQ-011 SHALL provide port io_busy  output  1  bus owned between START and STOP.
REQ-012 SHALL provide port io_glitch_count  output  8  saturating count of rejected glitches, both lines combined.

Function
REQ-013 Each pad input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Per line, a 4-bit counter SHALL increment each cycle while the synchronized value differs from the filtered output, and clear when they match.
REQ-015 When the counter would reach FILTER_CYCLES while still differing, the filtered output SHALL take the synchronized value and the counter SHALL clear.
REQ-016 Total latency from a stable pad change to the filtered output SHALL be exactly 2 + FILTER_CYCLES cycles.
REQ-017 A synchronized pulse shorter than FILTER_CYCLES cycles SHALL NOT change the filtered output.
REQ-018 A rejected glitch (counter nonzero, synchronized value returns to match) SHALL increment io_glitch_count by 1 per line; both lines in the same cycle SHALL add 2.
REQ-019 io_glitch_count SHALL saturate at 255; io_stats_clear SHALL win over a simultaneous increment.
REQ-020 START SHALL be detected when filtered SDA falls 1->0 while filtered SCL is 1 in both the current and previous cycle.
REQ-021 STOP SHALL be detected when filtered SDA rises 0->1 while filtered SCL is 1 in both the current and previous cycle.
REQ-022 SDA and SCL filtered edges in the same cycle SHALL generate no condition.
REQ-023 Condition FSM SHALL have states IDLE and BUSY: IDLE->BUSY on START; BUSY->IDLE on STOP; START in BUSY pulses io_start and stays in BUSY; STOP in IDLE pulses io_stop and stays in IDLE.
REQ-024 io_busy SHALL be 1 exactly in state BUSY; io_start/io_stop SHALL assert one cycle after the filtered SDA edge.

Reset
REQ-025 On io_reset_n low, synchronizer flops and filtered outputs SHALL reset to 1 (idle bus high), counters to 0, FSM to IDLE, io_start/io_stop/io_busy to 0, io_glitch_count to 0.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; after release no START/STOP SHALL be reported until a fresh SDA edge is filtered.

Configuration
REQ-027 Macro I2C_PAD_FILTER_COND_DETECT_EN defined SHALL compile in the START/STOP detection and the FSM per REQ-020..REQ-024.
REQ-028 Without I2C_PAD_FILTER_COND_DETECT_EN, io_start, io_stop and io_busy SHALL be constant 0, and the filtering and glitch count SHALL be unchanged.

Verification (FILTER_CYCLES=3, macro defined)
REQ-029 Reset release, both pads 1 for 10 cycles -> io_scl_read=io_sda_read=1, io_busy=0, io_glitch_count=0.
REQ-030 SDA pad low 2 cycles then high -> io_sda_read stays 1, io_glitch_count=1.
REQ-031 SCL=1, SDA pad 1->0 held -> io_sda_read=0 at cycle 5, io_start pulses at cycle 6, io_busy=1 from cycle 6; then SDA 0->1 with SCL=1 -> io_stop pulse, io_busy=0.
REQ-032 Both pads fall in the same cycle -> both filtered outputs fall in the same cycle, no io_start, io_busy stays 0.
REQ-033 300 single-cycle SDA glitches -> io_glitch_count=255; io_stats_clear held with a glitch in the same cycle -> io_glitch_count=0.
REQ-034 io_reset_n low while io_busy=1 -> io_busy=0 asynchronously, outputs=1, no io_stop pulse after release.
